// File: rtl/tone_mixer_pdm.sv
// -----------------------------------------------------------------------------
// tone_mixer_pdm
//
// Multi-voice square-wave tone generator. Each voice divides clk by a
// programmable half-period and contributes its volume to a mixed level while
// its phase is high. The mixed level drives a first-order sigma-delta
// modulator whose carry is the one-bit PDM audio output.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   voice counters advance only when high (mixer/PDM always run)
//   wr_en     in   single-cycle register write strobe
//   wr_voice  in   target voice index (writes to indices >= N_VOICES ignored)
//   wr_period in   half-period in clk cycles, 0 mutes the voice
//   wr_vol    in   voice volume
//   voice_sq  out  raw square phase per voice
//   level     out  registered mixed level
//   pdm_out   out  sigma-delta bitstream
//
// VOICE_W defaults to clog2(N_VOICES); it may be widened so that out-of-range
// indices can actually be presented on wr_voice.
// -----------------------------------------------------------------------------
module tone_mixer_pdm #(
  parameter int  N_VOICES = 4,
  parameter int  PERIOD_W = 16,
  parameter int  VOL_W    = 3,
  parameter int  VOICE_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1,
  localparam int LVL_W    = VOL_W + $clog2(N_VOICES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [VOICE_W-1:0]  wr_voice,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [VOL_W-1:0]    wr_vol,
  output logic [N_VOICES-1:0] voice_sq,
  output logic [LVL_W-1:0]    level,
  output logic                pdm_out
);

  logic [PERIOD_W-1:0] period_q [N_VOICES];
  logic [PERIOD_W-1:0] period_d [N_VOICES];
  logic [PERIOD_W-1:0] cnt_q    [N_VOICES];
  logic [PERIOD_W-1:0] cnt_d    [N_VOICES];
  logic [VOL_W-1:0]    vol_q    [N_VOICES];
  logic [VOL_W-1:0]    vol_d    [N_VOICES];
  logic [N_VOICES-1:0] phase_q, phase_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    acc_q, acc_d;
  logic                pdm_q, pdm_d;

  logic [N_VOICES-1:0] wr_sel;
  logic [LVL_W:0]      acc_sum;

  // One-hot write select; an index outside 0..N_VOICES-1 matches nothing.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    wr_sel = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (wr_en && (int'(wr_voice) == v)) wr_sel[v] = 1'b1;
    end
  end

  // Per-voice divider. A write takes priority over everything, including a
  // terminal count on the same edge, so a retrigger never produces a toggle.
  // Comparing against period-1 keeps cnt below period, so the largest period
  // cannot overflow the counter.
  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      period_d[v] = period_q[v];
      vol_d[v]    = vol_q[v];
      cnt_d[v]    = cnt_q[v];
      phase_d[v]  = phase_q[v];
      if (wr_sel[v]) begin
        period_d[v] = wr_period;
        vol_d[v]    = wr_vol;
        cnt_d[v]    = '0;
        phase_d[v]  = 1'b0;
      end else if (period_q[v] == '0) begin
        cnt_d[v]   = '0;
        phase_d[v] = 1'b0;
      end else if (ena) begin
        if (cnt_q[v] == period_q[v] - PERIOD_W'(1)) begin
          cnt_d[v]   = '0;
          phase_d[v] = ~phase_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] + PERIOD_W'(1);
        end
      end
    end
  end

  // Mixer: LVL_W is sized so the full-scale sum cannot wrap.
  always_comb begin
    level_d = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (phase_q[v]) level_d = level_d + LVL_W'(vol_q[v]);
    end
  end

  // First-order sigma-delta: the accumulator overflow is the output bit.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, level_q};
    acc_d   = acc_sum[LVL_W-1:0];
    pdm_d   = acc_sum[LVL_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the voice register arrays are small and their reset value is
      // architecturally visible (a muted voice), so they are reset like any
      // other flop rather than treated as uninitialised memory.
      for (int v = 0; v < N_VOICES; v++) begin
        period_q[v] <= '0;
        cnt_q[v]    <= '0;
        vol_q[v]    <= '0;
      end
      phase_q <= '0;
      level_q <= '0;
      acc_q   <= '0;
      pdm_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // level sees the old phase, pdm sees the old level.
      for (int v = 0; v < N_VOICES; v++) begin
        period_q[v] <= period_d[v];
        cnt_q[v]    <= cnt_d[v];
        vol_q[v]    <= vol_d[v];
      end
      phase_q <= phase_d;
      level_q <= level_d;
      acc_q   <= acc_d;
      pdm_q   <= pdm_d;
    end
  end

  assign voice_sq = phase_q;
  assign level    = level_q;
  assign pdm_out  = pdm_q;

endmodule

// File: tb/tb_tone_mixer_pdm.sv
// -----------------------------------------------------------------------------
// tb_tone_mixer_pdm
//
// Self-checking bench for tone_mixer_pdm. The reference model describes each
// voice by the number of enabled cycles elapsed since its last write; the
// phase is then (elapsed / period) mod 2. Mixer and PDM are modelled with
// plain integer arithmetic. A compare process checks every output on every
// falling edge while out of reset; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_tone_mixer_pdm;

  localparam int N   = 4;
  localparam int PW  = 16;
  localparam int VW  = 3;
  localparam int IW  = 3;
  localparam int LW  = 5;
  localparam int FS  = 1 << LW;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          wr_en;
  logic [IW-1:0] wr_voice;
  logic [PW-1:0] wr_period;
  logic [VW-1:0] wr_vol;
  logic [N-1:0]  voice_sq;
  logic [LW-1:0] level;
  logic          pdm_out;

  tone_mixer_pdm #(
    .N_VOICES (N),
    .PERIOD_W (PW),
    .VOL_W    (VW),
    .VOICE_W  (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_en     (wr_en),
    .wr_voice  (wr_voice),
    .wr_period (wr_period),
    .wr_vol    (wr_vol),
    .voice_sq  (voice_sq),
    .level     (level),
    .pdm_out   (pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_period  [N];
  int m_vol     [N];
  int m_elapsed [N];
  int m_level;
  int m_acc;
  int m_pdm;

  function automatic int m_phase(input int v);
    if (m_period[v] == 0) return 0;
    return (m_elapsed[v] / m_period[v]) % 2;
  endfunction

  function automatic int m_voice_vec();
    int r = 0;
    for (int v = 0; v < N; v++) r |= m_phase(v) << v;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < N; v++) begin
        m_period[v]  = 0;
        m_vol[v]     = 0;
        m_elapsed[v] = 0;
      end
      m_level = 0;
      m_acc   = 0;
      m_pdm   = 0;
    end else begin
      int s;
      int lvl;
      s       = m_acc + m_level;
      m_pdm   = (s >= FS) ? 1 : 0;
      m_acc   = s % FS;
      lvl = 0;
      for (int v = 0; v < N; v++) if (m_phase(v) == 1) lvl += m_vol[v];
      m_level = lvl;
      for (int v = 0; v < N; v++) begin
        if (wr_en && int'(wr_voice) == v) begin
          m_period[v]  = int'(wr_period);
          m_vol[v]     = int'(wr_vol);
          m_elapsed[v] = 0;
        end else if (ena && m_period[v] != 0) begin
          m_elapsed[v]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("voice_sq", int'(voice_sq), m_voice_vec());
      check("level",    int'(level),    m_level);
      check("pdm_out",  int'(pdm_out),  m_pdm);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int v, input int p, input int vol);
    wr_en     = 1'b1;
    wr_voice  = IW'(v);
    wr_period = PW'(p);
    wr_vol    = VW'(vol);
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic count_ones(input int cycles, output int ones);
    ones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      ones += int'(pdm_out);
    end
  endtask

  int ones;
  int max_lvl;
  int waited;
  logic [N-1:0] held;

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    wr_en     = 1'b0;
    wr_voice  = '0;
    wr_period = '0;
    wr_vol    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_voice_sq", int'(voice_sq), 0);
    check("reset_level",    int'(level),    0);
    check("reset_pdm",      int'(pdm_out),  0);

    // Single voice: period 3, volume 7.
    ena = 1'b1;
    write(0, 3, 7);
    check("v0_after_write", int'(voice_sq[0]), 0);
    tick(); tick();
    check("v0_before_toggle", int'(voice_sq[0]), 0);
    tick();
    check("v0_first_toggle", int'(voice_sq[0]), 1);
    check("level_lags_phase", int'(level), 0);
    ena = 1'b0;
    tick();
    check("level_single", int'(level), 7);
    tick(); tick();
    count_ones(32, ones);
    check("pdm_ones_level7", ones, 7);

    // Four voices, written with ena low so they start aligned.
    for (int v = 0; v < N; v++) write(v, 5, 7);
    check("mix_all_low", int'(voice_sq), 0);
    ena = 1'b1;
    max_lvl = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("mix_aligned", int'(voice_sq == '0 || voice_sq == '1), 1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    check("mix_peak_level", max_lvl, 28);
    waited = 0;
    while (voice_sq != '1 && waited < 20) begin
      tick();
      waited++;
    end
    check("mix_reached_high", int'(voice_sq), 15);
    ena = 1'b0;
    tick(); tick(); tick();
    check("mix_held_level", int'(level), 28);
    count_ones(32, ones);
    check("pdm_ones_level28", ones, 28);

    // Mute, out-of-range index, fastest period.
    ena = 1'b1;
    write(1, 0, 7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("v1_muted", int'(voice_sq[1]), 0);
    end
    write(4, 9, 1);
    tick(); tick();
    write(2, 1, 3);
    check("v2_fast_start", int'(voice_sq[2]), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("v2_fast", int'(voice_sq[2]), (i + 1) % 2);
    end

    // Retrigger on the terminal-count edge: the write wins.
    write(0, 4, 5);
    tick(); tick(); tick();
    check("v0_pre_collision", int'(voice_sq[0]), 0);
    write(0, 4, 5);
    check("v0_collision_no_toggle", int'(voice_sq[0]), 0);
    tick(); tick(); tick();
    check("v0_collision_wait", int'(voice_sq[0]), 0);
    tick();
    check("v0_collision_toggle", int'(voice_sq[0]), 1);

    // ena gating with phase high.
    write(0, 3, 2);
    repeat (4) tick();
    check("v0_gate_start", int'(voice_sq[0]), 1);
    ena = 1'b0;
    held = voice_sq;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_hold", int'(voice_sq == held), 1);
    end
    ena = 1'b1;
    tick();
    check("gate_resume_1", int'(voice_sq[0]), 1);
    tick();
    check("gate_resume_2", int'(voice_sq[0]), 0);

    // Asynchronous reset mid-run, away from any clock edge.
    write(3, 2, 6);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_voice_sq", int'(voice_sq), 0);
    check("async_rst_level",    int'(level),    0);
    check("async_rst_pdm",      int'(pdm_out),  0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_quiet", int'(voice_sq) + int'(level) + int'(pdm_out), 0);
    end

    // Randomized traffic, including out-of-range indices and long periods.
    for (int i = 0; i < 1500; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        wr_en     = 1'b1;
        wr_voice  = IW'($urandom_range(0, 7));
        wr_period = ($urandom_range(0, 15) == 0) ? PW'(16'hFFFF)
                                                 : PW'($urandom_range(0, 12));
        wr_vol    = VW'($urandom_range(0, 7));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
